// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 256-word instruction memory.
// Assembles big-endian words, checks an XOR checksum, then releases the core.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | after reset, core held in reset, waiting for load_req
// S_COUNT | waiting for the word-count byte (0 encodes 256)
// S_DATA  | shifting data bytes into words and writing them
// S_CHECK | waiting for the checksum byte
// S_RUN   | load good, core released
// S_ERR   | load aborted (checksum or timeout), core held in reset
module imem_loader #(
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rstd,
   input  logic        load_req,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        im_we,
   output logic [7:0]  im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_rstd,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [8:0]  words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_DATA, S_CHECK, S_RUN, S_ERR
   } state_t;

   localparam logic [19:0] TMR_LOAD = 20'(TIMEOUT - 1);

   state_t      state, state_nx;
   logic [1:0]  err_nx;
   logic        accept, last_word, tmr_tc, loading_nx;
   logic [19:0] tmr;
   logic [8:0]  word_cnt;
   logic [7:0]  word_idx;
   logic [7:0]  chk;
   logic [1:0]  lane;
   logic [23:0] word_sr;

   // in_ready is registered from the next state, so it equals "state is loading"
   assign accept     = in_valid & in_ready;
   assign last_word  = (words_loaded + 9'd1) == word_cnt;
   assign tmr_tc     = (tmr == 20'd0);
   assign loading_nx = (state_nx == S_COUNT) || (state_nx == S_DATA) || (state_nx == S_CHECK);

   always_ff @(posedge clk) begin
      if (rstd) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      err_nx   = err_code;
      case (state)
         S_IDLE, S_RUN, S_ERR: begin
            if (load_req) begin
               state_nx = S_COUNT;
               err_nx   = 2'b00;
            end
         end
         S_COUNT: begin
            if (accept) state_nx = S_DATA;
            else if (tmr_tc) begin
               state_nx = S_ERR;
               err_nx   = 2'b10;
            end
         end
         S_DATA: begin
            if (accept) begin
               if (lane == 2'd3 && last_word) state_nx = S_CHECK;
            end else if (tmr_tc) begin
               state_nx = S_ERR;
               err_nx   = 2'b10;
            end
         end
         S_CHECK: begin
            if (accept) begin
               if (in_data == chk) state_nx = S_RUN;
               else begin
                  state_nx = S_ERR;
                  err_nx   = 2'b01;
               end
            end else if (tmr_tc) begin
               state_nx = S_ERR;
               err_nx   = 2'b10;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstd) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         cpu_rstd <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_code <= 2'b00;
      end else begin
         in_ready <= loading_nx;
         busy     <= loading_nx;
         cpu_rstd <= (state_nx == S_RUN);
         done     <= (state_nx == S_RUN);
         error    <= (state_nx == S_ERR);
         err_code <= err_nx;
      end
   end

   // idle timer restarts on every accepted byte and on every state change
   always_ff @(posedge clk) begin
      if (rstd)                               tmr <= TMR_LOAD;
      else if (accept || state_nx != state)   tmr <= TMR_LOAD;
      else if (!tmr_tc)                       tmr <= tmr - 20'd1;
   end

   always_ff @(posedge clk) begin
      if (rstd) begin
         im_we        <= 1'b0;
         im_addr      <= 8'd0;
         im_wdata     <= 32'd0;
         words_loaded <= 9'd0;
         word_cnt     <= 9'd0;
         word_idx     <= 8'd0;
         chk          <= 8'd0;
         lane         <= 2'd0;
         word_sr      <= 24'd0;
      end else begin
         im_we <= 1'b0;
         if (accept && state == S_COUNT) begin
            word_cnt     <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            word_idx     <= 8'd0;
            lane         <= 2'd0;
            chk          <= 8'd0;
            words_loaded <= 9'd0;
         end else if (accept && state == S_DATA) begin
            word_sr <= {word_sr[15:0], in_data};
            chk     <= chk ^ in_data;
            lane    <= lane + 2'd1;
            if (lane == 2'd3) begin
               im_we        <= 1'b1;
               im_wdata     <= {word_sr, in_data};
               im_addr      <= word_idx;
               word_idx     <= word_idx + 8'd1;
               words_loaded <= words_loaded + 9'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, 256-word load, checksum error,
// timeout, reload from RUN and reset mid-load.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstd = 1'b1;
   logic        load_req = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready, im_we, cpu_rstd, busy, done, error;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic [1:0]  err_code;
   logic [8:0]  words_loaded;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          wr_cnt  = 0;
   int          base;
   logic [7:0]  last_addr = 8'd0;
   logic [31:0] mem [256];
   logic [7:0]  xsum;

   imem_loader #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rstd         (rstd),
      .load_req     (load_req),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_rstd     (cpu_rstd),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .err_code     (err_code),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (im_we) begin
         mem[im_addr] = im_wdata;
         last_addr    = im_addr;
         wr_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) begin
         send(w[k*8 +: 8]);
         xsum = xsum ^ w[k*8 +: 8];
      end
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, " in_ready"},     32'(in_ready), 32'd0);
      check({pfx, " im_we"},        32'(im_we), 32'd0);
      check({pfx, " im_addr"},      32'(im_addr), 32'd0);
      check({pfx, " im_wdata"},     im_wdata, 32'd0);
      check({pfx, " cpu_rstd"},     32'(cpu_rstd), 32'd0);
      check({pfx, " busy"},         32'(busy), 32'd0);
      check({pfx, " done"},         32'(done), 32'd0);
      check({pfx, " error"},        32'(error), 32'd0);
      check({pfx, " err_code"},     32'(err_code), 32'd0);
      check({pfx, " words_loaded"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin
      repeat (3) tick();
      check_reset_vals("rst");
      rstd = 1'b0;
      tick();
      in_data = 8'h55; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("idle ignores valid busy", 32'(busy), 32'd0);
      check("idle ignores valid we",   32'(wr_cnt), 32'd0);

      // single word load with im_we timing
      pulse_load();
      check("t1 busy",     32'(busy), 32'd1);
      check("t1 in_ready", 32'(in_ready), 32'd1);
      check("t1 cpu_rstd", 32'(cpu_rstd), 32'd0);
      base = wr_cnt;
      xsum = 8'h00;
      send(8'h01);
      send(8'h24); send(8'h01); send(8'h00);
      check("t1 we before 4th", 32'(im_we), 32'd0);
      send(8'h05);
      xsum = 8'h24 ^ 8'h01 ^ 8'h00 ^ 8'h05;
      check("t1 we",    32'(im_we), 32'd1);
      check("t1 addr",  32'(im_addr), 32'h00);
      check("t1 wdata", im_wdata, 32'h24010005);
      send(xsum);
      check("t1 we single",  32'(im_we), 32'd0);
      check("t1 done",       32'(done), 32'd1);
      check("t1 cpu_rstd r", 32'(cpu_rstd), 32'd1);
      check("t1 busy off",   32'(busy), 32'd0);
      check("t1 in_ready 0", 32'(in_ready), 32'd0);
      check("t1 words",      32'(words_loaded), 32'd1);
      check("t1 writes",     32'(wr_cnt - base), 32'd1);

      // full 256-word load
      pulse_load();
      base = wr_cnt;
      send(8'h00);
      for (int i = 0; i < 1024; i++) send(8'(i));
      send(8'h00);
      check("t2 writes",    32'(wr_cnt - base), 32'd256);
      check("t2 last addr", 32'(last_addr), 32'hFF);
      check("t2 mem0",      mem[0], 32'h00010203);
      check("t2 mem1",      mem[1], 32'h04050607);
      check("t2 mem128",    mem[128], 32'h00010203);
      check("t2 mem255",    mem[255], 32'hFCFDFEFF);
      check("t2 words",     32'(words_loaded), 32'd256);
      check("t2 done",      32'(done), 32'd1);
      check("t2 err_code",  32'(err_code), 32'd0);

      // reload from RUN, load_req mid-DATA ignored
      pulse_load();
      check("t5 cpu_rstd", 32'(cpu_rstd), 32'd0);
      check("t5 done",     32'(done), 32'd0);
      check("t5 busy",     32'(busy), 32'd1);
      base = wr_cnt;
      send(8'h01);
      send(8'hDE); send(8'hAD);
      pulse_load();
      check("t5 mid busy",     32'(busy), 32'd1);
      check("t5 mid in_ready", 32'(in_ready), 32'd1);
      send(8'hBE); send(8'hEF);
      send(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
      check("t5 mem0",   mem[0], 32'hDEADBEEF);
      check("t5 addr",   32'(last_addr), 32'h00);
      check("t5 writes", 32'(wr_cnt - base), 32'd1);
      check("t5 done",   32'(done), 32'd1);
      check("t5 words",  32'(words_loaded), 32'd1);

      // checksum mismatch
      pulse_load();
      base = wr_cnt;
      xsum = 8'h00;
      send(8'h02);
      send_word(32'h11223344);
      send_word(32'hAABBCCDD);
      send(~xsum);
      check("t3 writes",   32'(wr_cnt - base), 32'd2);
      check("t3 mem1",     mem[1], 32'hAABBCCDD);
      check("t3 error",    32'(error), 32'd1);
      check("t3 err_code", 32'(err_code), 32'b01);
      check("t3 cpu_rstd", 32'(cpu_rstd), 32'd0);
      check("t3 done",     32'(done), 32'd0);

      // timeout after 5 data bytes
      pulse_load();
      check("t4 err cleared", 32'(error), 32'd0);
      check("t4 code cleared", 32'(err_code), 32'd0);
      base = wr_cnt;
      send(8'h02);
      for (int i = 1; i <= 5; i++) send(8'(i));
      repeat (15) tick();
      check("t4 no err at 15", 32'(error), 32'd0);
      check("t4 ready at 15",  32'(in_ready), 32'd1);
      tick();
      check("t4 error",    32'(error), 32'd1);
      check("t4 err_code", 32'(err_code), 32'b10);
      check("t4 in_ready", 32'(in_ready), 32'd0);
      check("t4 writes",   32'(wr_cnt - base), 32'd1);
      check("t4 words",    32'(words_loaded), 32'd1);
      check("t4 mem0",     mem[0], 32'h01020304);

      // reset mid-load, then a clean load from address 0
      pulse_load();
      base = wr_cnt;
      send(8'h02);
      for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i));
      rstd = 1'b1;
      tick();
      check_reset_vals("t6");
      rstd = 1'b0;
      tick();
      check("t6 writes on rst", 32'(wr_cnt - base), 32'd1);
      pulse_load();
      base = wr_cnt;
      xsum = 8'h00;
      send(8'h01);
      send_word(32'hCAFE0123);
      send(xsum);
      check("t6 writes", 32'(wr_cnt - base), 32'd1);
      check("t6 addr",   32'(last_addr), 32'h00);
      check("t6 mem0",   mem[0], 32'hCAFE0123);
      check("t6 done",   32'(done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
